// File: rtl/vreg_stream_file_pkg.sv
// Shared constants and types for the streaming vector register file.
// Module parameters default to these values so the slice stays consistent.
package vreg_stream_file_pkg;

    localparam int DEF_NUM_VREGS    = 32;
    localparam int DEF_VSEL_W       = 8;
    localparam int DEF_NUM_ELEMENTS = 32;
    localparam int DEF_ELEM_W       = 16;
    localparam int DEF_LANES        = 8;
    localparam int DEF_BEATS        = DEF_NUM_ELEMENTS / DEF_LANES;
    localparam int DEF_BEAT_W       = (DEF_BEATS > 1) ? $clog2(DEF_BEATS) : 1;

    typedef logic [DEF_ELEM_W-1:0]  fp16_t;
    typedef logic [DEF_VSEL_W-1:0]  vsel_t;
    typedef fp16_t [DEF_LANES-1:0]  vreg_beat_t;
    typedef logic [DEF_LANES-1:0]   lane_mask_t;

    typedef enum logic { R_IDLE, R_STREAM } rd_state_t;
    typedef enum logic { W_IDLE, W_STREAM } wr_state_t;

endpackage

// File: rtl/vreg_stream_file_if.sv
// Read and write streaming handshakes between the issue side (master)
// and the register file (slave).
interface vreg_stream_file_if
    import vreg_stream_file_pkg::*;
#(
    parameter int VSEL_W = DEF_VSEL_W,
    parameter int LANES  = DEF_LANES,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int BEAT_W = DEF_BEAT_W
);
    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [VSEL_W-1:0]         rd_vs;
    logic                      rd_beat_valid;
    logic                      rd_beat_ready;
    logic [LANES*ELEM_W-1:0]   rd_beat_data;
    logic [BEAT_W-1:0]         rd_beat_idx;
    logic                      rd_beat_last;

    logic                      wr_req_valid;
    logic                      wr_req_ready;
    logic [VSEL_W-1:0]         wr_vd;
    logic                      wr_beat_valid;
    logic                      wr_beat_ready;
    logic [LANES*ELEM_W-1:0]   wr_beat_data;
    logic [LANES-1:0]          wr_beat_mask;

    logic                      busy;
    logic                      idx_err;

    modport master (
        output rd_req_valid, rd_vs, rd_beat_ready,
        output wr_req_valid, wr_vd, wr_beat_valid, wr_beat_data, wr_beat_mask,
        input  rd_req_ready, rd_beat_valid, rd_beat_data, rd_beat_idx, rd_beat_last,
        input  wr_req_ready, wr_beat_ready, busy, idx_err
    );

    modport slave (
        input  rd_req_valid, rd_vs, rd_beat_ready,
        input  wr_req_valid, wr_vd, wr_beat_valid, wr_beat_data, wr_beat_mask,
        output rd_req_ready, rd_beat_valid, rd_beat_data, rd_beat_idx, rd_beat_last,
        output wr_req_ready, wr_beat_ready, busy, idx_err
    );

endinterface

// File: rtl/vreg_stream_file_bank.sv
// Beat-organised storage: one registered beat-wide read port and one
// lane-masked beat-wide write port. Contents are intentionally not reset.
module vreg_stream_file_bank
    import vreg_stream_file_pkg::*;
#(
    parameter int NUM_VREGS = DEF_NUM_VREGS,
    parameter int BEATS     = DEF_BEATS,
    parameter int LANES     = DEF_LANES,
    parameter int ELEM_W    = DEF_ELEM_W,
    parameter int RIDX_W    = 5,
    parameter int BEAT_W    = DEF_BEAT_W
) (
    input  logic                         CLK,
    input  logic                         re_i,
    input  logic [RIDX_W-1:0]            rreg_i,
    input  logic [BEAT_W-1:0]            rbeat_i,
    output logic [LANES-1:0][ELEM_W-1:0] rdata_o,
    input  logic                         we_i,
    input  logic [RIDX_W-1:0]            wreg_i,
    input  logic [BEAT_W-1:0]            wbeat_i,
    input  logic [LANES-1:0][ELEM_W-1:0] wdata_i,
    input  logic [LANES-1:0]             wmask_i
);

    logic [LANES-1:0][ELEM_W-1:0] mem_q [NUM_VREGS][BEATS];
    logic [LANES-1:0][ELEM_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (re_i) begin
            rdata_q <= mem_q[rreg_i][rbeat_i];
        end
        if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_i[l]) begin
                    mem_q[wreg_i][wbeat_i][l] <= wdata_i[l];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vreg_stream_file.sv
// Streaming vector register file: read and write FSMs with RAW/WAR
// interlocks in front of a beat-organised storage bank.
module vreg_stream_file
    import vreg_stream_file_pkg::*;
#(
    parameter int NUM_VREGS    = DEF_NUM_VREGS,
    parameter int VSEL_W       = DEF_VSEL_W,
    parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter int ELEM_W       = DEF_ELEM_W,
    parameter int LANES        = DEF_LANES,
    parameter int BEATS        = NUM_ELEMENTS / LANES,
    parameter int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    vreg_stream_file_if.slave  bus
);

    localparam int                RIDX_W     = (NUM_VREGS > 1) ? $clog2(NUM_VREGS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [VSEL_W:0]   VREG_LIMIT = (VSEL_W + 1)'(NUM_VREGS);

    rd_state_t          rd_state_q;
    wr_state_t          wr_state_q;
    logic [VSEL_W-1:0]  rd_vs_q, wr_vd_q;
    logic [BEAT_W-1:0]  rd_idx_q, wr_cnt_q;
    logic               rd_oob_q, wr_oob_q, idx_err_q;

    logic rd_idle, wr_idle, read_hazard, write_hazard;
    logic rd_req_fire, wr_req_fire, rd_beat_fire, wr_beat_fire;
    logic rd_last, wr_last, rd_req_oob, wr_req_oob, idx_err_d;
    logic [RIDX_W-1:0]            bank_rreg;
    logic [BEAT_W-1:0]            bank_rbeat;
    logic                         bank_re, bank_we;
    logic [LANES-1:0][ELEM_W-1:0] bank_rdata;

    assign rd_idle = (rd_state_q == R_IDLE);
    assign wr_idle = (wr_state_q == W_IDLE);

    // A pending write request beats a same-cycle read of the same register,
    // so reads always observe the completed write.
    assign read_hazard  = (!wr_idle && bus.rd_vs == wr_vd_q)
                        || (bus.wr_req_valid && wr_idle && bus.rd_vs == bus.wr_vd);
    assign write_hazard = !rd_idle && bus.wr_vd == rd_vs_q;

    assign bus.rd_req_ready = nRST && rd_idle && !read_hazard;
    assign bus.wr_req_ready = nRST && wr_idle && !write_hazard;

    assign rd_req_fire  = bus.rd_req_valid && bus.rd_req_ready;
    assign wr_req_fire  = bus.wr_req_valid && bus.wr_req_ready;
    assign rd_beat_fire = !rd_idle && bus.rd_beat_ready;
    assign wr_beat_fire = !wr_idle && bus.wr_beat_valid;
    assign rd_last      = (rd_idx_q == LAST_BEAT);
    assign wr_last      = (wr_cnt_q == LAST_BEAT);
    assign rd_req_oob   = {1'b0, bus.rd_vs} >= VREG_LIMIT;
    assign wr_req_oob   = {1'b0, bus.wr_vd} >= VREG_LIMIT;
    assign idx_err_d    = (rd_req_fire && rd_req_oob) || (wr_req_fire && wr_req_oob);

    // The bank is only re-read when the visible beat advances, which keeps
    // data stable under backpressure.
    always_comb begin
        bank_rreg  = rd_vs_q[RIDX_W-1:0];
        bank_rbeat = rd_idx_q + 1'b1;
        if (rd_req_fire) begin
            bank_rreg  = bus.rd_vs[RIDX_W-1:0];
            bank_rbeat = '0;
        end
    end

    assign bank_re = rd_req_fire || (rd_beat_fire && !rd_last);
    assign bank_we = wr_beat_fire && !wr_oob_q;

    vreg_stream_file_bank #(
        .NUM_VREGS (NUM_VREGS),
        .BEATS     (BEATS),
        .LANES     (LANES),
        .ELEM_W    (ELEM_W),
        .RIDX_W    (RIDX_W),
        .BEAT_W    (BEAT_W)
    ) u_bank (
        .CLK     (CLK),
        .re_i    (bank_re),
        .rreg_i  (bank_rreg),
        .rbeat_i (bank_rbeat),
        .rdata_o (bank_rdata),
        .we_i    (bank_we),
        .wreg_i  (wr_vd_q[RIDX_W-1:0]),
        .wbeat_i (wr_cnt_q),
        .wdata_i (bus.wr_beat_data),
        .wmask_i (bus.wr_beat_mask)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_state_q <= R_IDLE;
            rd_vs_q    <= '0;
            rd_idx_q   <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_req_fire) begin
                        rd_state_q <= R_STREAM;
                        rd_vs_q    <= bus.rd_vs;
                        rd_idx_q   <= '0;
                        rd_oob_q   <= rd_req_oob;
                    end
                end
                R_STREAM: begin
                    if (bus.rd_beat_ready) begin
                        rd_idx_q <= rd_last ? '0 : rd_idx_q + 1'b1;
                        if (rd_last) rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_state_q <= W_IDLE;
            wr_vd_q    <= '0;
            wr_cnt_q   <= '0;
            wr_oob_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_req_fire) begin
                        wr_state_q <= W_STREAM;
                        wr_vd_q    <= bus.wr_vd;
                        wr_cnt_q   <= '0;
                        wr_oob_q   <= wr_req_oob;
                    end
                end
                W_STREAM: begin
                    if (bus.wr_beat_valid) begin
                        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
                        if (wr_last) wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) idx_err_q <= 1'b0;
        else       idx_err_q <= idx_err_d;
    end

    // Out-of-range reads stream zeros without touching storage.
    assign bus.rd_beat_valid = !rd_idle;
    assign bus.rd_beat_data  = (!rd_idle && !rd_oob_q) ? bank_rdata : '0;
    assign bus.rd_beat_idx   = rd_idx_q;
    assign bus.rd_beat_last  = !rd_idle && rd_last;
    assign bus.wr_beat_ready = !wr_idle;
    assign bus.busy          = !(rd_idle && wr_idle);
    assign bus.idx_err       = idx_err_q;

endmodule

// File: tb/tb_vreg_stream_file.sv
// Directed self-checking bench for vreg_stream_file: data paths, masks,
// interlocks, backpressure, out-of-range indices and mid-stream reset.
module tb_vreg_stream_file;
    import vreg_stream_file_pkg::*;

    typedef logic [127:0] beats_t [4];

    logic   CLK = 1'b0;
    logic   nRST = 1'b0;
    int     tests = 0;
    int     failures = 0;
    beats_t expB;

    vreg_stream_file_if bus ();

    vreg_stream_file dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rampBeat(input logic [15:0] base, input int b);
        logic [127:0] r;
        for (int l = 0; l < 8; l++) r[16*l +: 16] = base + 16'(b*8 + l);
        return r;
    endfunction

    task automatic setRamp(input logic [15:0] base);
        for (int b = 0; b < 4; b++) expB[b] = rampBeat(base, b);
    endtask

    task automatic setConst(input logic [127:0] v);
        for (int b = 0; b < 4; b++) expB[b] = v;
    endtask

    task automatic applyStimulus(input logic rdv, input logic [7:0] vs, input logic wrv, input logic [7:0] vd);
        bus.rd_req_valid = rdv;
        bus.rd_vs        = vs;
        bus.wr_req_valid = wrv;
        bus.wr_vd        = vd;
    endtask

    task automatic wrRequest(input logic [7:0] vd);
        int n = 0;
        bus.wr_vd = vd;
        bus.wr_req_valid = 1'b1;
        #1;
        while (!bus.wr_req_ready && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 40) checkOutput("wr_req_timeout", 0, 1);
        @(posedge CLK); #1;
        bus.wr_req_valid = 1'b0;
        checkOutput("wr_idx_err", bus.idx_err, vd >= 8'd32);
    endtask

    task automatic wrBeat(input logic [127:0] data, input lane_mask_t mask);
        bus.wr_beat_valid = 1'b1;
        bus.wr_beat_data  = data;
        bus.wr_beat_mask  = mask;
        checkOutput("wr_beat_ready", bus.wr_beat_ready, 1);
        @(posedge CLK); #1;
        bus.wr_beat_valid = 1'b0;
    endtask

    task automatic writeReg(input logic [7:0] vd, input lane_mask_t mask);
        wrRequest(vd);
        for (int b = 0; b < 4; b++) wrBeat(expB[b], mask);
    endtask

    task automatic readReg(input logic [7:0] vs, input bit randStall);
        int n = 0;
        bus.rd_vs = vs;
        bus.rd_req_valid = 1'b1;
        bus.rd_beat_ready = 1'b0;
        #1;
        while (!bus.rd_req_ready && n < 40) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 40) checkOutput("rd_req_timeout", 0, 1);
        @(posedge CLK); #1;
        bus.rd_req_valid = 1'b0;
        checkOutput("rd_beat0_valid", bus.rd_beat_valid, 1);
        checkOutput("rd_idx_err", bus.idx_err, vs >= 8'd32);
        for (int b = 0; b < 4; b++) begin
            if (randStall) begin
                repeat ($urandom_range(0, 3)) begin
                    checkOutput("stall_data", bus.rd_beat_data, expB[b]);
                    checkOutput("stall_idx", bus.rd_beat_idx, b);
                    checkOutput("stall_last", bus.rd_beat_last, b == 3);
                    @(posedge CLK); #1;
                end
            end
            bus.rd_beat_ready = 1'b1;
            checkOutput("rd_valid", bus.rd_beat_valid, 1);
            checkOutput("rd_data", bus.rd_beat_data, expB[b]);
            checkOutput("rd_idx", bus.rd_beat_idx, b);
            checkOutput("rd_last", bus.rd_beat_last, b == 3);
            @(posedge CLK); #1;
            bus.rd_beat_ready = 1'b0;
            if (b == 0) checkOutput("idx_err_once", bus.idx_err, 0);
        end
        checkOutput("rd_done", bus.rd_beat_valid, 0);
    endtask

    initial begin
        logic [127:0] r8b0, r8b1;
        applyStimulus(0, 0, 0, 0);
        bus.rd_beat_ready = 0; bus.wr_beat_valid = 0;
        bus.wr_beat_data = '0; bus.wr_beat_mask = '0;

        #1;
        checkOutput("reset_rd_req_ready", bus.rd_req_ready, 0);
        checkOutput("reset_wr_req_ready", bus.wr_req_ready, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_rd_valid", bus.rd_beat_valid, 0);
        checkOutput("reset_idx_err", bus.idx_err, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        #1;
        checkOutput("post_reset_rd_ready", bus.rd_req_ready, 1);
        checkOutput("post_reset_wr_ready", bus.wr_req_ready, 1);

        // Full write then read of v3.
        setRamp(16'h3C00);
        writeReg(8'd3, 8'hFF);
        checkOutput("ramp_beat2", expB[2], 128'h3C17_3C16_3C15_3C14_3C13_3C12_3C11_3C10);
        readReg(8'd3, 0);

        // Masked write leaves even lanes at zero.
        setConst('0);
        writeReg(8'd5, 8'hFF);
        setConst({8{16'hFFFF}});
        writeReg(8'd5, 8'hAA);
        setConst({4{32'hFFFF_0000}});
        readReg(8'd5, 0);

        // RAW interlock on v7, while v8 reads proceed.
        setRamp(16'h1000);
        writeReg(8'd8, 8'hFF);
        wrRequest(8'd7);
        applyStimulus(1, 8'd8, 0, 0);
        #1;
        checkOutput("raw_other_ready", bus.rd_req_ready, 1);
        readReg(8'd8, 0);
        applyStimulus(1, 8'd7, 0, 0);
        repeat (5) begin
            #1;
            checkOutput("raw_stall_block", bus.rd_req_ready, 0);
            @(posedge CLK); #1;
        end
        setRamp(16'h2000);
        for (int b = 0; b < 4; b++) begin
            checkOutput("raw_beat_block", bus.rd_req_ready, 0);
            wrBeat(expB[b], 8'hFF);
        end
        checkOutput("raw_release", bus.rd_req_ready, 1);
        readReg(8'd7, 0);

        // WAR interlock on v2.
        setRamp(16'h4000);
        writeReg(8'd2, 8'hFF);
        applyStimulus(1, 8'd2, 0, 0);
        #1;
        @(posedge CLK); #1;
        bus.rd_req_valid = 1'b0;
        bus.wr_vd = 8'd2; bus.wr_req_valid = 1'b1;
        repeat (6) begin
            #1;
            checkOutput("war_stall_block", bus.wr_req_ready, 0);
            @(posedge CLK); #1;
        end
        for (int b = 0; b < 4; b++) begin
            checkOutput("war_beat_block", bus.wr_req_ready, 0);
            checkOutput("war_rd_data", bus.rd_beat_data, expB[b]);
            bus.rd_beat_ready = 1'b1;
            @(posedge CLK); #1;
            bus.rd_beat_ready = 1'b0;
        end
        checkOutput("war_release", bus.wr_req_ready, 1);
        @(posedge CLK); #1;
        bus.wr_req_valid = 1'b0;
        setRamp(16'h5000);
        for (int b = 0; b < 4; b++) wrBeat(expB[b], 8'hFF);
        readReg(8'd2, 0);

        // Same-cycle tie on v4: write wins.
        applyStimulus(1, 8'd4, 1, 8'd4);
        #1;
        checkOutput("tie_wr_ready", bus.wr_req_ready, 1);
        checkOutput("tie_rd_ready", bus.rd_req_ready, 0);
        @(posedge CLK); #1;
        bus.wr_req_valid = 1'b0;
        checkOutput("tie_rd_blocked", bus.rd_req_ready, 0);
        checkOutput("tie_busy", bus.busy, 1);
        setRamp(16'h6000);
        for (int b = 0; b < 4; b++) wrBeat(expB[b], 8'hFF);
        checkOutput("tie_rd_release", bus.rd_req_ready, 1);
        bus.rd_req_valid = 1'b0;
        readReg(8'd4, 0);

        // Random backpressure on a known register.
        setRamp(16'h3C00);
        readReg(8'd3, 1);
        readReg(8'd3, 1);

        // Out-of-range: zero read, discarded write (v40 aliases v8 in low bits).
        setConst('0);
        readReg(8'd40, 0);
        setRamp(16'hBAD0);
        writeReg(8'd40, 8'hFF);
        setRamp(16'h1000);
        readReg(8'd8, 0);

        // Asynchronous reset during write beat 2.
        setRamp(16'h7000);
        writeReg(8'd6, 8'hFF);
        r8b0 = rampBeat(16'h8000, 0);
        r8b1 = rampBeat(16'h8000, 1);
        wrRequest(8'd6);
        wrBeat(r8b0, 8'hFF);
        wrBeat(r8b1, 8'hFF);
        bus.wr_beat_valid = 1'b1;
        bus.wr_beat_data  = rampBeat(16'h8000, 2);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("rst_wr_beat_ready", bus.wr_beat_ready, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_wr_req_ready", bus.wr_req_ready, 0);
        checkOutput("rst_rd_req_ready", bus.rd_req_ready, 0);
        @(posedge CLK); #1;
        bus.wr_beat_valid = 1'b0;
        nRST = 1'b1;
        #1;
        checkOutput("rst_release_ready", bus.wr_req_ready, 1);
        expB[0] = r8b0;
        expB[1] = r8b1;
        readReg(8'd6, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
